// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Issue/capture stage that wraps the combinational ALU16 as a
//               two-stage pipelined unit: request FIFO -> issue register ->
//               result register. ALU_OP_COUNT_EN enables the completed-result
//               counter on op_count.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int DATA_W = 4,
    parameter int SEL_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [SEL_W-1:0]  alu_s,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  out_sel,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       op_count
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_ENTRY_W = SEL_W + 2 * DATA_W;

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W:0]     r_wr_ptr;
    logic [c_PTR_W:0]     r_rd_ptr;
    logic                 r_iss_valid;
    logic [SEL_W-1:0]     r_alu_s;
    logic [DATA_W-1:0]    r_alu_a;
    logic [DATA_W-1:0]    r_alu_b;
    logic                 r_out_valid;
    logic [SEL_W-1:0]     r_out_sel;
    logic [DATA_W-1:0]    r_out_data;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_s2_adv;
    logic                 w_s1_load;
    logic [c_ENTRY_W-1:0] w_head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        w_empty   = (r_wr_ptr == r_rd_ptr);
        w_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                    (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
        w_push    = in_valid && !w_full;
        w_s2_adv  = r_iss_valid && (!r_out_valid || out_ready);
        w_s1_load = !w_empty && (!r_iss_valid || w_s2_adv);
        w_head    = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= {in_sel, in_a, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_s1_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Issue register: reads only the registered head, so a push is never
    // forwarded straight into the ALU in the cycle it arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_valid <= 1'b0;
            r_alu_s     <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
        end else if (w_s1_load) begin
            r_iss_valid                 <= 1'b1;
            {r_alu_s, r_alu_a, r_alu_b} <= w_head;
        end else if (w_s2_adv) begin
            r_iss_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sel   <= '0;
            r_out_data  <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= 1'b1;
            r_out_sel   <= r_alu_s;
            r_out_data  <= alu_o;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef ALU_OP_COUNT_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (r_out_valid && out_ready) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`else
    assign op_count = 16'd0;
`endif

    assign in_ready  = !w_full;
    assign alu_s     = r_alu_s;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign out_valid = r_out_valid;
    assign out_sel   = r_out_sel;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Self-checking bench for alu_op_sequencer with an o=a^b^s ALU
//               stub and a queue-based reference model of the result stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

`ifdef ALU_OP_COUNT_EN
    localparam bit c_COUNT_ON = 1'b1;
`else
    localparam bit c_COUNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_sel;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic [3:0]  alu_s;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_o;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_sel;
    logic [3:0]  out_data;
    logic [15:0] op_count;

    alu_op_sequencer #(.DATA_W(4), .SEL_W(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_a      (in_a),
        .in_b      (in_b),
        .alu_s     (alu_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_o     (alu_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .out_data  (out_data),
        .op_count  (op_count)
    );

    assign alu_o = alu_a ^ alu_b ^ alu_s;

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sel;
        logic [3:0] data;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_push = 0;
    int          n_pop = 0;
    int          cyc = 0;
    int          last_pop_cyc = -10;
    int          run_len = 0;
    logic [15:0] exp_cnt = 16'd0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_word = 8'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes at the falling edge, then step past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
            exp_cnt    = 16'd0;
        end else begin
            check("op_count", {16'd0, op_count}, c_COUNT_ON ? {16'd0, exp_cnt} : 32'd0);
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_hold", {24'd0, out_sel, out_data}, {24'd0, prev_word});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("out_unexpected", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("out_sel", {28'd0, out_sel}, {28'd0, e.sel});
                    check("out_data", {28'd0, out_data}, {28'd0, e.data});
                end
                n_pop++;
                run_len      = (cyc == last_pop_cyc + 1) ? run_len + 1 : 1;
                last_pop_cyc = cyc;
                exp_cnt      = exp_cnt + 16'd1;
            end
            if (in_valid && in_ready) begin
                e.sel  = in_sel;
                e.data = in_a ^ in_b ^ in_sel;
                q.push_back(e);
                n_push++;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_sel, out_data};
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drive(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        in_valid = 1'b1;
        in_sel   = s;
        in_a     = a;
        in_b     = b;
    endtask

    int base;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu", {20'd0, alu_s, alu_a, alu_b}, 32'd0);
        check("rst_out", {24'd0, out_sel, out_data}, 32'd0);
        check("rst_op_count", {16'd0, op_count}, 32'd0);

        // Single op and latency
        drive(4'b0000, 4'b0101, 4'b0110);
        cycle();
        in_valid = 1'b0;
        check("lat_no_forward", {28'd0, alu_a}, 32'd0);
        cycle();
        check("lat_alu_a", {28'd0, alu_a}, 32'h5);
        check("lat_alu_b", {28'd0, alu_b}, 32'h6);
        check("lat_out_early", {31'd0, out_valid}, 32'd0);
        cycle();
        check("lat_out_valid", {31'd0, out_valid}, 32'd1);
        check("lat_out_data", {28'd0, out_data}, 32'h3);
        check("lat_out_sel", {28'd0, out_sel}, 32'h0);
        idle(4);

        // Streaming all selects
        base = n_pop;
        for (int i = 0; i < 16; i++) begin
            drive(i[3:0], 4'd5, 4'd6);
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            cycle();
        end
        idle(6);
        check("stream_count", n_pop - base, 32'd16);
        check("stream_consecutive", run_len, 32'd16);

        // Backpressure: fills output, issue and FIFO
        out_ready = 1'b0;
        base = n_push;
        for (int k = 0; k < 6; k++) begin
            drive(4'($urandom), 4'($urandom), 4'($urandom));
            check("bp_ready", {31'd0, in_ready}, 32'd1);
            cycle();
        end
        drive(4'hA, 4'h3, 4'hC);
        for (int k = 0; k < 3; k++) begin
            check("bp_full", {31'd0, in_ready}, 32'd0);
            cycle();
        end
        check("bp_accepts", n_push - base, 32'd6);
        in_valid = 1'b0;
        out_ready = 1'b1;
        base = n_pop;
        idle(10);
        check("bp_drained", n_pop - base, 32'd6);

        // Full with simultaneous pop: no push on the popping edge
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(4'($urandom), 4'($urandom), 4'($urandom));
            cycle();
        end
        drive(4'h7, 4'h1, 4'h2);
        out_ready = 1'b1;
        check("fp_full", {31'd0, in_ready}, 32'd0);
        base = n_push;
        cycle();
        check("fp_ready_after_pop", {31'd0, in_ready}, 32'd1);
        cycle();
        check("fp_push_next", n_push - base, 32'd1);
        idle(10);
        check("fp_drained", q.size(), 32'd0);

        // Reset with requests in flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(4'($urandom), 4'($urandom), 4'($urandom));
            cycle();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_alu", {20'd0, alu_s, alu_a, alu_b}, 32'd0);
        out_ready = 1'b1;
        base = n_pop;
        idle(8);
        check("mid_rst_no_stale", n_pop - base, 32'd0);

        // Counter: 20 completed handshakes after reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(4'($urandom), 4'($urandom), 4'($urandom));
            cycle();
        end
        idle(6);
        check("count_20", {16'd0, op_count}, c_COUNT_ON ? 32'd20 : 32'd0);

        // Randomized traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = 4'($urandom);
            in_a      = 4'($urandom);
            in_b      = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(10);
        check("rand_drained", q.size(), 32'd0);
        check("rand_idle_valid", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
